// File: rtl/display_pkg.sv
// display_pkg: shared constants for the 7-seg scan controller.
// Active-low patterns, bit7=a .. bit1=g, bit0=dp.
package display_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] SEG_MINUS  = 8'b11111101;
  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;
  localparam int         NUM_DIGITS = 4;

  localparam logic [7:0] SEG_0 = 8'b00000011;
  localparam logic [7:0] SEG_1 = 8'b10011111;
  localparam logic [7:0] SEG_2 = 8'b00100101;
  localparam logic [7:0] SEG_3 = 8'b00001101;
  localparam logic [7:0] SEG_4 = 8'b10011001;
  localparam logic [7:0] SEG_5 = 8'b01001001;
  localparam logic [7:0] SEG_6 = 8'b01000001;
  localparam logic [7:0] SEG_7 = 8'b00011111;
  localparam logic [7:0] SEG_8 = 8'b00000001;
  localparam logic [7:0] SEG_9 = 8'b00001001;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: code + dp flag -> active-low segment pattern.
// Ports: code[3:0], dp (1 = light point), seg[7:0].
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] pat;

  always_comb begin
    pat = SEG_BLANK;
    unique case (code)
      4'd0:       pat = SEG_0;
      4'd1:       pat = SEG_1;
      4'd2:       pat = SEG_2;
      4'd3:       pat = SEG_3;
      4'd4:       pat = SEG_4;
      4'd5:       pat = SEG_5;
      4'd6:       pat = SEG_6;
      4'd7:       pat = SEG_7;
      4'd8:       pat = SEG_8;
      4'd9:       pat = SEG_9;
      CODE_MINUS: pat = SEG_MINUS;
      default:    pat = SEG_BLANK;
    endcase
    seg = {pat[7:1], pat[0] & ~dp};
  end

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: 4-digit multiplexed 7-seg scan.
// Ports: clk, rst, enable, load, digits_in, dp_sel, blank_lz -> update_pending, an, seg.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [2:0]  dp_sel,
  input  logic        blank_lz,
  output logic        update_pending,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pdig_q, pdig_d;
  logic [2:0]    pdp_q, pdp_d;
  logic          pblz_q, pblz_d;
  logic [15:0]   ddig_q, ddig_d;
  logic [2:0]    ddp_q, ddp_d;
  logic          dblz_q, dblz_d;
  logic          upd_q, upd_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic          tick, frame;
  logic [3:0]    lz;
  logic          hi_zero;
  logic [3:0]    code, dcode;
  logic          dp_on, guard;
  logic [7:0]    pat;

  always_comb begin
    tick    = enable && (presc_q == LAST);
    frame   = tick && (idx_q == 2'd3);
    presc_d = presc_q;
    idx_d   = idx_q;
    if (enable) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) idx_d = idx_q + 2'd1;
    end
  end

  // load on the frame edge goes straight to the display
  always_comb begin
    pdig_d = pdig_q;
    pdp_d  = pdp_q;
    pblz_d = pblz_q;
    ddig_d = ddig_q;
    ddp_d  = ddp_q;
    dblz_d = dblz_q;
    upd_d  = upd_q;
    if (frame && load) begin
      ddig_d = digits_in;
      ddp_d  = dp_sel;
      dblz_d = blank_lz;
      upd_d  = 1'b0;
    end else if (frame && upd_q) begin
      ddig_d = pdig_q;
      ddp_d  = pdp_q;
      dblz_d = pblz_q;
      upd_d  = 1'b0;
    end else if (load) begin
      pdig_d = digits_in;
      pdp_d  = dp_sel;
      pblz_d = blank_lz;
      upd_d  = 1'b1;
    end
  end

  // zero run from the top, stopping at the point position
  always_comb begin
    lz      = '0;
    hi_zero = dblz_q;
    for (int i = 3; i >= 1; i--) begin
      hi_zero = hi_zero && (ddig_q[i*4 +: 4] == 4'd0);
      lz[i]   = hi_zero && (ddp_q[2] || (3'(i) > ddp_q));
    end
  end

  always_comb begin
    code  = ddig_q[{idx_q, 2'b00} +: 4];
    dcode = lz[idx_q] ? CODE_BLANK : code;
    dp_on = ({1'b0, idx_q} == ddp_q);
    guard = int'(presc_q) < GUARD;
  end

  seg7_decode u_dec (
    .code (dcode),
    .dp   (dp_on),
    .seg  (pat)
  );

  always_comb begin
    an_d  = 4'hF;
    seg_d = SEG_BLANK;
    if (enable) begin
      seg_d = pat;
      if (!guard) an_d = ~(4'b0001 << idx_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      pdig_q  <= '0;
      pdp_q   <= 3'd7;
      pblz_q  <= 1'b0;
      ddig_q  <= '0;
      ddp_q   <= 3'd7;
      dblz_q  <= 1'b0;
      upd_q   <= 1'b0;
      an_q    <= 4'hF;
      seg_q   <= SEG_BLANK;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pdig_q  <= pdig_d;
      pdp_q   <= pdp_d;
      pblz_q  <= pblz_d;
      ddig_q  <= ddig_d;
      ddp_q   <= ddp_d;
      dblz_q  <= dblz_d;
      upd_q   <= upd_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign update_pending = upd_q;
  assign an             = an_q;
  assign seg            = seg_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed scoreboard bench.
// TICK_DIV=4, GUARD=1.
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [2:0]  dp_sel = 3'd7;
  logic        blank_lz = 1'b0;
  logic        update_pending;
  logic [3:0]  an;
  logic [7:0]  seg;

  display_scan_controller #(
    .TICK_DIV (4),
    .GUARD    (1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .load           (load),
    .digits_in      (digits_in),
    .dp_sel         (dp_sel),
    .blank_lz       (blank_lz),
    .update_pending (update_pending),
    .an             (an),
    .seg            (seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       upd;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  int          m_presc, m_idx;
  logic [15:0] m_pd, m_dd;
  logic [2:0]  m_pp, m_dp;
  logic        m_pb, m_db, m_upd;
  logic [7:0]  cap [4];

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] pat(input logic [3:0] c);
    case (c)
      4'd0: return 8'h03;
      4'd1: return 8'h9F;
      4'd2: return 8'h25;
      4'd3: return 8'h0D;
      4'd4: return 8'h99;
      4'd5: return 8'h49;
      4'd6: return 8'h41;
      4'd7: return 8'h1F;
      4'd8: return 8'h01;
      4'd9: return 8'h09;
      4'd10: return 8'hFD;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int i);
    logic [7:0] p;
    logic blank;
    blank = 1'b0;
    if (m_db && i != 0 && (m_dp > 3 || i > int'(m_dp))) begin
      blank = 1'b1;
      for (int j = i; j < 4; j++)
        if (m_dd[j*4 +: 4] != 4'd0) blank = 1'b0;
    end
    p = blank ? 8'hFF : pat(m_dd[i*4 +: 4]);
    if (i == int'(m_dp)) p[0] = 1'b0;
    return p;
  endfunction

  task automatic model_reset();
    m_presc = 0; m_idx = 0;
    m_pd = '0; m_dd = '0;
    m_pp = 3'd7; m_dp = 3'd7;
    m_pb = 1'b0; m_db = 1'b0; m_upd = 1'b0;
  endtask

  task automatic cyc(input logic lo);
    exp_t e;
    bit tk, bnd;
    load  = lo;
    e.an  = 4'hF;
    e.seg = 8'hFF;
    if (enable) begin
      e.seg = exp_seg(m_idx);
      if (m_presc >= 1) e.an = ~(4'b0001 << m_idx);
    end
    tk  = enable && (m_presc == 3);
    bnd = tk && (m_idx == 3);
    if (bnd && lo) begin
      m_dd = digits_in; m_dp = dp_sel; m_db = blank_lz;
      m_upd = 1'b0;
    end else if (bnd && m_upd) begin
      m_dd = m_pd; m_dp = m_pp; m_db = m_pb;
      m_upd = 1'b0;
    end else if (lo) begin
      m_pd = digits_in; m_pp = dp_sel; m_pb = blank_lz;
      m_upd = 1'b1;
    end
    if (enable) begin
      m_presc = tk ? 0 : m_presc + 1;
      if (tk) m_idx = (m_idx + 1) % 4;
    end
    e.upd = m_upd;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    load = 1'b0;
    e = sbq.pop_front();
    chk("an", {4'h0, an}, {4'h0, e.an});
    chk("seg", seg, e.seg);
    chk("upd", {7'd0, update_pending}, {7'd0, e.upd});
    case (an)
      4'b1110: cap[0] = seg;
      4'b1101: cap[1] = seg;
      4'b1011: cap[2] = seg;
      4'b0111: cap[3] = seg;
      default: ;
    endcase
  endtask

  task automatic show(input logic [15:0] d, input logic [2:0] dp,
                      input logic blz);
    digits_in = d; dp_sel = dp; blank_lz = blz;
    cyc(1'b1);
    for (int k = 0; k < 40 && m_upd; k++) cyc(1'b0);
    chk("commit", {7'd0, update_pending}, 8'h00);
    for (int k = 0; k < 4; k++) cap[k] = 8'h00;
    repeat (16) cyc(1'b0);
  endtask

  task automatic show4(input string tag, input logic [7:0] e3,
                       input logic [7:0] e2, input logic [7:0] e1,
                       input logic [7:0] e0);
    chk({tag, "_d3"}, cap[3], e3);
    chk({tag, "_d2"}, cap[2], e2);
    chk({tag, "_d1"}, cap[1], e1);
    chk({tag, "_d0"}, cap[0], e0);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_an", {4'h0, an}, 8'h0F);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_upd", {7'd0, update_pending}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an2", {4'h0, an}, 8'h0F);
    chk("rst_seg2", seg, 8'hFF);
    rst = 1'b0;
    model_reset();

    repeat (10) cyc(1'b0);

    show(16'h1234, 3'd7, 1'b0);
    show4("n1234", 8'h9F, 8'h25, 8'h0D, 8'h99);

    show(16'h0050, 3'd7, 1'b1);
    show4("lz50", 8'hFF, 8'hFF, 8'h49, 8'h03);

    show(16'h0005, 3'd2, 1'b1);
    show4("lzdp", 8'hFF, 8'h02, 8'h03, 8'h49);

    show(16'hA001, 3'd7, 1'b0);
    show4("minus", 8'hFD, 8'h03, 8'h03, 8'h9F);

    show(16'hBCDF, 3'd0, 1'b0);
    show4("blank", 8'hFF, 8'hFF, 8'hFF, 8'hFE);

    digits_in = 16'h1111;
    cyc(1'b1);
    show(16'h2222, 3'd7, 1'b0);
    show4("last", 8'h25, 8'h25, 8'h25, 8'h25);

    for (int k = 0; k < 20 && !(m_presc == 3 && m_idx == 3); k++)
      cyc(1'b0);
    digits_in = 16'h9876; dp_sel = 3'd1; blank_lz = 1'b0;
    cyc(1'b1);
    chk("bnd_pend", {7'd0, update_pending}, 8'h00);
    repeat (16) cyc(1'b0);
    show4("bnd", 8'h09, 8'h01, 8'h1E, 8'h41);

    repeat (2) cyc(1'b0);
    enable = 1'b0;
    cyc(1'b0);
    chk("dis_an", {4'h0, an}, 8'h0F);
    chk("dis_seg", seg, 8'hFF);
    digits_in = 16'h5555; dp_sel = 3'd7;
    cyc(1'b1);
    repeat (6) cyc(1'b0);
    chk("dis_pend", {7'd0, update_pending}, 8'h01);
    enable = 1'b1;
    for (int k = 0; k < 40 && m_upd; k++) cyc(1'b0);
    repeat (16) cyc(1'b0);
    show4("reen", 8'h49, 8'h49, 8'h49, 8'h49);

    for (int k = 0; k < 8 && m_presc != 0; k++) cyc(1'b0);
    digits_in = 16'h1234;
    cyc(1'b1);
    chk("pre_rst_pend", {7'd0, update_pending}, 8'h01);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_an", {4'h0, an}, 8'h0F);
    chk("mid_rst_seg", seg, 8'hFF);
    chk("mid_rst_upd", {7'd0, update_pending}, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) cap[k] = 8'h00;
    repeat (16) cyc(1'b0);
    show4("post_rst", 8'h03, 8'h03, 8'h03, 8'h03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
